// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encoding, time-field
// widths and a small state-classification helper.
package stopwatch_pkg;

  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam int CS_W  = 7;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_LAP     = 2'b10,
    S_STOPPED = 2'b11
  } state_t;

  // True in the one state where the display shows the frozen lap capture.
  function automatic logic shows_lap(input state_t s);
    return (s == S_LAP);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button front end: two-flop synchronizer followed by a rising-edge detector
// that emits a single-cycle event per press.
module btn_edge (
  input  logic clk,
  input  logic res,
  input  logic btn,
  output logic ev
);

  logic       sync1_r;
  logic       sync2_r;
  logic       hist_r;
  logic [1:0] valid_r;

  // History starts high and only tracks the synchronizer once the pipeline has
  // refilled after reset, so a button held through reset never looks like a press.
  always_ff @(posedge clk) begin
    if (res) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      hist_r  <= 1'b1;
      valid_r <= 2'b00;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      valid_r <= {valid_r[0], 1'b1};
      if (valid_r[1]) begin
        hist_r <= sync2_r;
      end else begin
        hist_r <= hist_r;
      end
    end
  end

  assign ev = valid_r[1] & sync2_r & ~hist_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop and lap/reset buttons drive the counter
// enable, clear pulse, lap capture and the displayed time.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int LAP_W = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             btn_ss,
  input  logic             btn_lr,
  input  logic [5:0]       cnt_min,
  input  logic [5:0]       cnt_sec,
  input  logic [6:0]       cnt_cs,
  output logic             run,
  output logic             clr,
  output logic [5:0]       disp_min,
  output logic [5:0]       disp_sec,
  output logic [6:0]       disp_cs,
  output logic [LAP_W-1:0] lap_cnt,
  output logic [1:0]       state
);

  localparam logic [LAP_W-1:0] LAP_MAX = {LAP_W{1'b1}};
  localparam logic [LAP_W-1:0] LAP_ONE = LAP_W'(1);

  logic ev_ss;
  logic ev_lr;

  state_t           state_r;
  logic             run_r;
  logic             clr_r;
  logic [LAP_W-1:0] lap_cnt_r;
  logic [MIN_W-1:0] lap_min_r;
  logic [SEC_W-1:0] lap_sec_r;
  logic [CS_W-1:0]  lap_cs_r;

  btn_edge u_edge_ss (
    .clk (clk),
    .res (res),
    .btn (btn_ss),
    .ev  (ev_ss)
  );

  btn_edge u_edge_lr (
    .clk (clk),
    .res (res),
    .btn (btn_lr),
    .ev  (ev_lr)
  );

  // Control FSM; start/stop is checked first so it wins over a simultaneous lap/reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r   <= S_IDLE;
      run_r     <= 1'b0;
      clr_r     <= 1'b0;
      lap_cnt_r <= '0;
      lap_min_r <= '0;
      lap_sec_r <= '0;
      lap_cs_r  <= '0;
    end else begin
      clr_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (ev_ss) begin
            state_r <= S_RUN;
            run_r   <= 1'b1;
          end else if (ev_lr) begin
            clr_r <= 1'b1;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RUN: begin
          if (ev_ss) begin
            state_r <= S_STOPPED;
            run_r   <= 1'b0;
          end else if (ev_lr) begin
            state_r   <= S_LAP;
            lap_min_r <= cnt_min;
            lap_sec_r <= cnt_sec;
            lap_cs_r  <= cnt_cs;
            if (lap_cnt_r != LAP_MAX) begin
              lap_cnt_r <= lap_cnt_r + LAP_ONE;
            end else begin
              lap_cnt_r <= lap_cnt_r;
            end
          end else begin
            state_r <= S_RUN;
          end
        end
        S_LAP: begin
          if (ev_ss) begin
            state_r <= S_STOPPED;
            run_r   <= 1'b0;
          end else if (ev_lr) begin
            state_r <= S_RUN;
          end else begin
            state_r <= S_LAP;
          end
        end
        S_STOPPED: begin
          if (ev_ss) begin
            state_r <= S_RUN;
            run_r   <= 1'b1;
          end else if (ev_lr) begin
            state_r   <= S_IDLE;
            clr_r     <= 1'b1;
            lap_cnt_r <= '0;
            lap_min_r <= '0;
            lap_sec_r <= '0;
            lap_cs_r  <= '0;
          end else begin
            state_r <= S_STOPPED;
          end
        end
        default: begin
          state_r <= S_IDLE;
          run_r   <= 1'b0;
        end
      endcase
    end
  end

  // Display mux: frozen lap capture while in LAP, live counter otherwise.
  always_comb begin
    disp_min = cnt_min;
    disp_sec = cnt_sec;
    disp_cs  = cnt_cs;
    if (shows_lap(state_r)) begin
      disp_min = lap_min_r;
      disp_sec = lap_sec_r;
      disp_cs  = lap_cs_r;
    end else begin
      disp_min = cnt_min;
      disp_sec = cnt_sec;
      disp_cs  = cnt_cs;
    end
  end

  assign run     = run_r;
  assign clr     = clr_r;
  assign lap_cnt = lap_cnt_r;
  assign state   = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with hand-computed expectations.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic [5:0] cnt_min = 6'd0;
  logic [5:0] cnt_sec = 6'd0;
  logic [6:0] cnt_cs = 7'd0;
  logic       run;
  logic       clr;
  logic [5:0] disp_min;
  logic [5:0] disp_sec;
  logic [6:0] disp_cs;
  logic [3:0] lap_cnt;
  logic [1:0] state;

  int n_cmp = 0;
  int n_fail = 0;

  stopwatch_ctrl #(.LAP_W(4)) dut (
    .clk      (clk),
    .res      (res),
    .btn_ss   (btn_ss),
    .btn_lr   (btn_lr),
    .cnt_min  (cnt_min),
    .cnt_sec  (cnt_sec),
    .cnt_cs   (cnt_cs),
    .run      (run),
    .clr      (clr),
    .disp_min (disp_min),
    .disp_sec (disp_sec),
    .disp_cs  (disp_cs),
    .lap_cnt  (lap_cnt),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press: the transition lands on the 3rd edge after the level is sampled.
  task automatic press(input logic ss, input logic lr);
    btn_ss = ss;
    btn_lr = lr;
    step(3);
  endtask

  task automatic release_btns();
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    step(3);
  endtask

  task automatic do_reset();
    res = 1'b1;
    step(2);
    res = 1'b0;
    step(3);
  endtask

  task automatic test_reset();
    cnt_min = 6'd1; cnt_sec = 6'd2; cnt_cs = 7'd3;
    do_reset();
    n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b want 00", state); end
    n_cmp++; if (run !== 1'b0) begin n_fail++; $display("FAIL reset_run got %b want 0", run); end
    n_cmp++; if (clr !== 1'b0) begin n_fail++; $display("FAIL reset_clr got %b want 0", clr); end
    n_cmp++; if (lap_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_lapcnt got %0d want 0", lap_cnt); end
    n_cmp++; if ({disp_min, disp_sec, disp_cs} !== {6'd1, 6'd2, 7'd3}) begin n_fail++;
      $display("FAIL reset_disp got %0d:%0d:%0d want 1:2:3", disp_min, disp_sec, disp_cs); end
  endtask

  task automatic test_start();
    btn_ss = 1'b1;
    step(2);
    n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL start_early got %b want 00", state); end
    step(1);
    n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL start_state got %b want 01", state); end
    n_cmp++; if (run !== 1'b1) begin n_fail++; $display("FAIL start_run got %b want 1", run); end
    step(10);
    n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL start_hold got %b want 01", state); end
    release_btns();
  endtask

  task automatic test_lap();
    cnt_min = 6'd2; cnt_sec = 6'd15; cnt_cs = 7'd37;
    press(1'b0, 1'b1);
    n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL lap_state got %b want 10", state); end
    n_cmp++; if (lap_cnt !== 4'd1) begin n_fail++; $display("FAIL lap_cnt got %0d want 1", lap_cnt); end
    n_cmp++; if (run !== 1'b1) begin n_fail++; $display("FAIL lap_run got %b want 1", run); end
    cnt_min = 6'd2; cnt_sec = 6'd16; cnt_cs = 7'd5;
    #1;
    n_cmp++; if ({disp_min, disp_sec, disp_cs} !== {6'd2, 6'd15, 7'd37}) begin n_fail++;
      $display("FAIL lap_freeze got %0d:%0d:%0d want 2:15:37", disp_min, disp_sec, disp_cs); end
    release_btns();
    press(1'b0, 1'b1);
    n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL lap_back_state got %b want 01", state); end
    n_cmp++; if ({disp_min, disp_sec, disp_cs} !== {6'd2, 6'd16, 7'd5}) begin n_fail++;
      $display("FAIL lap_back_disp got %0d:%0d:%0d want 2:16:5", disp_min, disp_sec, disp_cs); end
    n_cmp++; if (lap_cnt !== 4'd1) begin n_fail++; $display("FAIL lap_back_cnt got %0d want 1", lap_cnt); end
    release_btns();
  endtask

  task automatic test_stop_clear();
    press(1'b1, 1'b0);
    n_cmp++; if (state !== 2'b11) begin n_fail++; $display("FAIL stop_state got %b want 11", state); end
    n_cmp++; if (run !== 1'b0) begin n_fail++; $display("FAIL stop_run got %b want 0", run); end
    release_btns();
    press(1'b0, 1'b1);
    n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL clear_state got %b want 00", state); end
    n_cmp++; if (clr !== 1'b1) begin n_fail++; $display("FAIL clear_pulse got %b want 1", clr); end
    n_cmp++; if (lap_cnt !== 4'd0) begin n_fail++; $display("FAIL clear_lapcnt got %0d want 0", lap_cnt); end
    step(1);
    n_cmp++; if (clr !== 1'b0) begin n_fail++; $display("FAIL clear_width got %b want 0", clr); end
    release_btns();
    // Lap/reset in IDLE: stays IDLE with one clr pulse.
    press(1'b0, 1'b1);
    n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL idle_clr_state got %b want 00", state); end
    n_cmp++; if (clr !== 1'b1) begin n_fail++; $display("FAIL idle_clr_pulse got %b want 1", clr); end
    step(1);
    n_cmp++; if (clr !== 1'b0) begin n_fail++; $display("FAIL idle_clr_width got %b want 0", clr); end
    release_btns();
  endtask

  task automatic test_both();
    press(1'b1, 1'b0); release_btns();
    press(1'b0, 1'b1); release_btns();
    press(1'b0, 1'b1); release_btns();
    n_cmp++; if (state !== 2'b01 || lap_cnt !== 4'd1) begin n_fail++;
      $display("FAIL both_setup got state %b lap %0d want 01 1", state, lap_cnt); end
    cnt_min = 6'd9; cnt_sec = 6'd9; cnt_cs = 7'd9;
    press(1'b1, 1'b1);
    n_cmp++; if (state !== 2'b11) begin n_fail++; $display("FAIL both_state got %b want 11", state); end
    n_cmp++; if (run !== 1'b0) begin n_fail++; $display("FAIL both_run got %b want 0", run); end
    n_cmp++; if (lap_cnt !== 4'd1) begin n_fail++; $display("FAIL both_lapcnt got %0d want 1", lap_cnt); end
    release_btns();
  endtask

  task automatic test_saturate();
    logic [3:0] exp_lc;
    press(1'b0, 1'b1); release_btns();
    press(1'b1, 1'b0); release_btns();
    for (int i = 1; i <= 17; i++) begin
      cnt_min = 6'(i); cnt_sec = 6'(i + 1); cnt_cs = 7'(i + 2);
      press(1'b0, 1'b1);
      exp_lc = (i > 15) ? 4'd15 : 4'(i);
      n_cmp++; if (lap_cnt !== exp_lc || state !== 2'b10) begin n_fail++;
        $display("FAIL sat_lap%0d got lap %0d state %b want %0d 10", i, lap_cnt, state, exp_lc); end
      release_btns();
      if (i < 17) begin
        press(1'b0, 1'b1);
        release_btns();
      end
    end
    cnt_min = 6'd40; cnt_sec = 6'd41; cnt_cs = 7'd42;
    #1;
    n_cmp++; if ({disp_min, disp_sec, disp_cs} !== {6'd17, 6'd18, 7'd19}) begin n_fail++;
      $display("FAIL sat_capture got %0d:%0d:%0d want 17:18:19", disp_min, disp_sec, disp_cs); end
  endtask

  task automatic test_reset_hold();
    btn_ss = 1'b1;
    res = 1'b1;
    step(2);
    res = 1'b0;
    step(8);
    n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL hold_state got %b want 00", state); end
    n_cmp++; if (run !== 1'b0) begin n_fail++; $display("FAIL hold_run got %b want 0", run); end
    release_btns();
    press(1'b1, 1'b0);
    n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL hold_repress got %b want 01", state); end
    release_btns();
    cnt_min = 6'd3; cnt_sec = 6'd4; cnt_cs = 7'd5;
    press(1'b0, 1'b1);
    release_btns();
    n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL mid_lap got %b want 10", state); end
    cnt_min = 6'd7; cnt_sec = 6'd8; cnt_cs = 7'd9;
    res = 1'b1;
    step(1);
    n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL mid_reset_state got %b want 00", state); end
    n_cmp++; if (run !== 1'b0) begin n_fail++; $display("FAIL mid_reset_run got %b want 0", run); end
    n_cmp++; if (lap_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_reset_lapcnt got %0d want 0", lap_cnt); end
    n_cmp++; if ({disp_min, disp_sec, disp_cs} !== {6'd7, 6'd8, 7'd9}) begin n_fail++;
      $display("FAIL mid_reset_disp got %0d:%0d:%0d want 7:8:9", disp_min, disp_sec, disp_cs); end
    res = 1'b0;
    step(3);
  endtask

  initial begin
    test_reset();
    test_start();
    test_lap();
    test_stop_clear();
    test_both();
    test_saturate();
    test_reset_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter LAP_W, default 4: width of the lap counter output.
REQ-002 clk  input  1  single clock for the whole block, rising-edge.
REQ-003 res  input  1  reset, synchronous, active-high.
REQ-004 btn_ss  input  1  start/stop button level, asynchronous to clk.
REQ-005 btn_lr  input  1  lap/reset button level, asynchronous to clk.
REQ-006 cnt_min  input  6  live minutes from the stopwatch counter.
REQ-007 cnt_sec  input  6  live seconds from the stopwatch counter.
REQ-008 cnt_cs  input  7  live centiseconds from the stopwatch counter.
REQ-009 run  output  1  counter enable; 0 = counter holds.
REQ-010 clr  output  1  one-cycle clear pulse to the counter.
REQ-011 disp_min  output  6  displayed minutes.
REQ-012 disp_sec  output  6  displayed seconds.
REQ-013 disp_cs  output  7  displayed centiseconds.
REQ-014 lap_cnt  output  LAP_W  number of laps taken.
REQ-015 state  output  2  current FSM state: IDLE=00, RUN=01, LAP=10, STOPPED=11.

Function
REQ-016 Each button SHALL pass a 2-flop synchronizer, then a rising-edge detector producing a 1-cycle event (ev_ss, ev_lr).
REQ-017 A button rising level SHALL cause its FSM transition on the 3rd rising clk edge after it is first sampled high; holding the button SHALL produce exactly one event.
REQ-018 IDLE: ev_ss -> RUN; ev_lr -> stay IDLE and pulse clr for 1 cycle.
REQ-019 RUN: ev_ss -> STOPPED; ev_lr -> LAP, capturing cnt_min/cnt_sec/cnt_cs into the lap registers on the same edge, and incrementing lap_cnt.
REQ-020 LAP: ev_ss -> STOPPED (display freeze released); ev_lr -> RUN (freeze released, no capture, lap_cnt unchanged).
REQ-021 STOPPED: ev_ss -> RUN; ev_lr -> IDLE, with a 1-cycle clr pulse, lap_cnt cleared to 0, and lap registers cleared to 0.
REQ-022 If ev_ss and ev_lr occur in the same cycle, ev_ss SHALL take priority and ev_lr SHALL be discarded.
REQ-023 run SHALL be 1 exactly when state is RUN or LAP; it is a registered output.
REQ-024 clr SHALL be registered, asserted in the cycle after the transition edge, and never held longer than 1 cycle.
REQ-025 In LAP, disp_* SHALL show the lap registers; in all other states disp_* SHALL show cnt_* combinationally.
REQ-026 lap_cnt SHALL saturate at 2^LAP_W-1; further laps still capture but do not increment it.

Reset
REQ-027 res high at a rising clk edge SHALL force state=IDLE, run=0, clr=0, lap_cnt=0, and lap registers=0.
REQ-028 Synchronizer flops SHALL reset to 0; edge-detector history flops SHALL reset to 1, so that a button held through reset release generates no event until it has been released and pressed again.
REQ-029 Reset asserted mid-operation (any state, including during a clr pulse) SHALL take effect on that edge, overriding any pending event.

Structure
REQ-030 Package stopwatch_pkg SHALL hold the state encoding and the widths MIN_W=6, SEC_W=6, CS_W=7.
REQ-031 Sub-module btn_edge (synchronizer plus edge detector, with the reset values in REQ-028) SHALL be instantiated once per button.

Verification
REQ-032 Reset, then press btn_ss -> run=1 and state=01 on the 3rd edge; a held button gives no second event.
REQ-033 In RUN with cnt = 2:15:37, press btn_lr -> state=10, disp = 2:15:37 frozen while cnt_* advances, lap_cnt=1; press btn_lr again -> state=01, disp follows cnt_*.
REQ-034 RUN -> btn_ss -> STOPPED (run=0) -> btn_lr -> IDLE with clr high for exactly 1 cycle and lap_cnt=0.
REQ-035 Press both buttons in the same cycle while in RUN -> STOPPED only; no capture, lap_cnt unchanged.
REQ-036 Take 17 laps with LAP_W=4 -> lap_cnt saturates at 15, and the lap registers hold the 17th capture.
REQ-037 Hold btn_ss high across reset deassertion -> no event; release and press -> RUN. Assert res while in LAP -> IDLE, run=0, disp = live cnt_*.
